// File: rtl/nn_input_feeder.sv
// nn_input_feeder: buffers one host input vector and serves it to the network fill/req handshake
module nn_input_feeder #(
  parameter int N_INPUTS = 2,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              net_rst,
  output logic              net_fill,
  input  logic              net_ack_fill,
  input  logic              net_rd_strobe,
  input  logic [ADDR_W-1:0] net_rd_addr,
  output logic [DATA_W-1:0] net_rd_data,
  output logic              net_req,
  input  logic              net_ack_network,
  output logic              done,
  output logic [15:0]       vec_count,
  output logic              addr_err
);
  typedef enum logic [1:0] {LOAD, NRST, FILL, RUN} state_t;
  state_t state_q, state_d;
  logic s_ready_q, s_ready_d, net_rst_q, net_rst_d, net_fill_q, net_fill_d;
  logic net_req_q, net_req_d, done_q, done_d, addr_err_q, addr_err_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [15:0] vec_count_q, vec_count_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  // sized to the full address space so any read index is a legal array index
  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] mem_d [2**ADDR_W];
  logic oor;
  assign oor = {1'b0, net_rd_addr} >= (ADDR_W+1)'(N_INPUTS);
  always_comb begin
    state_d     = state_q;
    s_ready_d   = s_ready_q;
    net_rst_d   = 1'b0;
    net_fill_d  = net_fill_q;
    net_req_d   = net_req_q;
    done_d      = 1'b0;
    addr_err_d  = addr_err_q;
    rd_data_d   = rd_data_q;
    vec_count_d = vec_count_q;
    wr_cnt_d    = wr_cnt_q;
    mem_d       = mem_q;
    case (state_q)
      LOAD: if (s_valid && s_ready_q) begin
        mem_d[wr_cnt_q] = s_data;
        if (wr_cnt_q == ADDR_W'(N_INPUTS - 1)) begin
          wr_cnt_d  = '0;
          s_ready_d = 1'b0;
          net_rst_d = 1'b1;
          state_d   = NRST;
        end else begin
          wr_cnt_d = wr_cnt_q + 1'b1;
        end
      end
      NRST: begin
        net_fill_d = 1'b1;
        state_d    = FILL;
      end
      FILL: begin
        if (net_rd_strobe) begin
          rd_data_d  = oor ? '0 : mem_q[net_rd_addr];
          addr_err_d = addr_err_q | oor;
        end
        if (net_ack_fill) begin
          net_fill_d = 1'b0;
          net_req_d  = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: if (net_ack_network) begin
        net_req_d   = 1'b0;
        done_d      = 1'b1;
        vec_count_d = vec_count_q + 16'd1;
        s_ready_d   = 1'b1;
        state_d     = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      s_ready_q   <= 1'b1;
      net_rst_q   <= 1'b0;
      net_fill_q  <= 1'b0;
      net_req_q   <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
      rd_data_q   <= '0;
      vec_count_q <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      s_ready_q   <= s_ready_d;
      net_rst_q   <= net_rst_d;
      net_fill_q  <= net_fill_d;
      net_req_q   <= net_req_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
      rd_data_q   <= rd_data_d;
      vec_count_q <= vec_count_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  assign s_ready     = s_ready_q;
  assign net_rst     = net_rst_q;
  assign net_fill    = net_fill_q;
  assign net_req     = net_req_q;
  assign done        = done_q;
  assign addr_err    = addr_err_q;
  assign net_rd_data = rd_data_q;
  assign vec_count   = vec_count_q;
endmodule

// File: tb/tb_nn_input_feeder.sv
// tb_nn_input_feeder: table-driven vectors on a 2-input feeder plus a 3-input feeder for range and reset cases
module tb_nn_input_feeder;
  logic clk = 0, rst = 1, s_valid = 0, ack_fill = 0, strobe = 0, ack_net = 0;
  logic [7:0] s_data = 0;
  logic [1:0] rd_addr = 0;
  logic s_ready, nrst, fill, req, done, addr_err;
  logic [7:0] rd_data;
  logic [15:0] vec;
  logic s_ready3, nrst3, fill3, req3, done3, addr_err3;
  logic [7:0] rd_data3;
  logic [15:0] vec3;
  int nvec = 0, nerr = 0, nrst_cnt = 0, done_cnt = 0;

  nn_input_feeder #(.N_INPUTS(2), .DATA_W(8), .ADDR_W(1)) u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .net_rst(nrst), .net_fill(fill), .net_ack_fill(ack_fill), .net_rd_strobe(strobe),
    .net_rd_addr(rd_addr[0:0]), .net_rd_data(rd_data), .net_req(req),
    .net_ack_network(ack_net), .done(done), .vec_count(vec), .addr_err(addr_err));

  nn_input_feeder #(.N_INPUTS(3), .DATA_W(8), .ADDR_W(2)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready3),
    .net_rst(nrst3), .net_fill(fill3), .net_ack_fill(ack_fill), .net_rd_strobe(strobe),
    .net_rd_addr(rd_addr), .net_rd_data(rd_data3), .net_req(req3),
    .net_ack_network(ack_net), .done(done3), .vec_count(vec3), .addr_err(addr_err3));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (nrst) nrst_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  a0, a1;
    int          gap;
    logic        first_hi;
    logic        same;
    logic [7:0]  e0, e1;
    logic [15:0] ev;
    int          en;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0] = '{8'h05, 8'hFD, 0, 1'b0, 1'b0, 8'h05, 8'hFD, 16'd1, 1};
    tbl[1] = '{8'h01, 8'h02, 2, 1'b0, 1'b1, 8'h01, 8'h02, 16'd2, 2};
    tbl[2] = '{8'h07, 8'hF8, 1, 1'b1, 1'b0, 8'hF8, 8'h07, 16'd3, 3};
    tbl[3] = '{8'h80, 8'h7F, 3, 1'b1, 1'b1, 8'h7F, 8'h80, 16'd4, 4};
    tick(3);
    rst = 0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_net_rst", nrst, 0);
    chk("rst_fill", fill, 0);
    chk("rst_req", req, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_vec", vec, 0);
    chk("rst_addr_err", addr_err, 0);
    for (int i = 0; i < 4; i++) begin
      vec_t r;
      r = tbl[i];
      ack_fill = 1; ack_net = 1; tick; ack_fill = 0; ack_net = 0;
      chk("load_ack_fill", fill, 0);
      chk("load_ack_req", req, 0);
      chk("load_ack_done", done, 0);
      chk("load_ready", s_ready, 1);
      s_valid = 1; s_data = r.a0; tick;
      chk("ready_mid", s_ready, 1);
      s_valid = 0; tick(r.gap);
      s_valid = 1; s_data = r.a1; tick;
      s_data = 8'h55;
      chk("ready_drop", s_ready, 0);
      chk("nrst_pulse", nrst, 1);
      chk("fill_early", fill, 0);
      tick;
      chk("nrst_end", nrst, 0);
      chk("fill_up", fill, 1);
      strobe = 1; rd_addr = {1'b0, r.first_hi}; tick; strobe = 0;
      chk("rd0", rd_data, r.e0);
      tick;
      chk("rd0_hold", rd_data, r.e0);
      strobe = 1; rd_addr = {1'b0, ~r.first_hi}; ack_fill = r.same; tick; strobe = 0;
      chk("rd1", rd_data, r.e1);
      if (!r.same) begin
        chk("fill_wait", fill, 1);
        ack_fill = 1; tick;
      end
      ack_fill = 0;
      chk("fill_down", fill, 0);
      chk("req_up", req, 1);
      strobe = 1; rd_addr = {1'b0, r.first_hi}; tick(3); strobe = 0;
      chk("run_hold", rd_data, r.e1);
      chk("req_hold", req, 1);
      s_valid = 0; ack_net = 1; tick; ack_net = 0;
      chk("done_up", done, 1);
      chk("req_down", req, 0);
      chk("ready_back", s_ready, 1);
      chk("vec_count", vec, r.ev);
      tick;
      chk("done_once", done, 0);
      chk("nrst_total", nrst_cnt, r.en);
      chk("done_total", done_cnt, r.en);
    end
    rst = 1; tick(2); rst = 0;
    chk("r3_addr_err", addr_err3, 0);
    s_valid = 1;
    s_data = 8'd10; tick;
    s_data = 8'd20; tick;
    s_data = 8'd30; tick;
    s_valid = 0;
    chk("r3_nrst", nrst3, 1);
    tick;
    chk("r3_fill", fill3, 1);
    strobe = 1; rd_addr = 2'd3; tick; strobe = 0;
    chk("r3_oor_data", rd_data3, 0);
    chk("r3_oor_err", addr_err3, 1);
    strobe = 1; rd_addr = 2'd2; tick; strobe = 0;
    chk("r3_rd2", rd_data3, 8'h1E);
    chk("r3_err_sticky", addr_err3, 1);
    ack_fill = 1; tick; ack_fill = 0;
    chk("r3_req", req3, 1);
    ack_net = 1; tick; ack_net = 0;
    chk("r3_done", done3, 1);
    chk("r3_vec", vec3, 1);
    chk("r3_err_after", addr_err3, 1);
    tick;
    s_valid = 1;
    s_data = 8'd1; tick;
    s_data = 8'd2; tick;
    s_data = 8'd3; tick;
    s_valid = 0; tick;
    ack_fill = 1; tick; ack_fill = 0;
    chk("r3_run", req3, 1);
    rst = 1; tick; rst = 0;
    chk("mid_req", req3, 0);
    chk("mid_ready", s_ready3, 1);
    chk("mid_vec", vec3, 0);
    chk("mid_err", addr_err3, 0);
    chk("mid_fill", fill3, 0);
    ack_net = 1; tick; ack_net = 0;
    chk("late_ack_done", done3, 0);
    chk("late_ack_vec", vec3, 0);
    chk("late_ack_req", req3, 0);
    s_valid = 1; s_data = 8'd9; tick;
    s_valid = 0; rst = 1; tick; rst = 0;
    s_valid = 1;
    s_data = 8'd4; tick;
    s_data = 8'd5; tick;
    chk("partial_ready", s_ready3, 1);
    s_data = 8'd6; tick;
    s_valid = 0; tick;
    chk("partial_fill", fill3, 1);
    strobe = 1; rd_addr = 2'd0; tick; strobe = 0;
    chk("partial_rd0", rd_data3, 8'd4);
    strobe = 1; rd_addr = 2'd2; tick; strobe = 0;
    chk("partial_rd2", rd_data3, 8'd6);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
